// File: rtl/bits_packet_sequencer.sv
// ---------------------------------------------------------------------------
// bits_packet_sequencer
//
// Header/payload sequencer for the BITS packet decoder. Sits between the
// bit-window shifter (upstream) and the literal-number datapath number_top.
// It parses the 3-bit version and 3-bit type ID of each packet. It hands
// literal payloads to number_top and parses operator length fields. It also
// tells the shifter how many bits to drop. Operator nesting is not tracked
// here; a downstream operator-stack block consumes op_valid/op_len.
//
// Optional feature macro: BITS_VERSION_SUM_EN
//   defined   -> version_sum accumulates every parsed version (mod 2^SUM_W)
//   undefined -> no accumulator is built, version_sum is tied to 0
//
// Ports
//   clk, resetB        clock, synchronous active-low reset
//   start              pulse, begin parsing at the current window (ignored
//                      while busy)
//   stream_end         upstream has no bits beyond win_count
//   win_bits/win_count bit window (bit 79 = next bit) and its valid length
//   consume/consume_n  registered pulse: shifter drops consume_n bits
//   lit_enable         one-cycle enable to number_top
//   lit_bits           numberFromBits to number_top (= win_bits)
//   lit_valid_nibbles  validNibbles from number_top (registered there)
//   lit_number         number from number_top (left-justified nibbles)
//   pkt_valid          pulse, header parsed; pkt_version/pkt_type hold it
//   literal_valid      pulse, literal_value holds the decoded literal
//   op_valid           pulse, op_len_type/op_len hold the length field
//   version_sum        running sum of parsed versions
//   busy               state is not IDLE/DONE/ERR
//   done / error       sticky end-of-stream / malformed-stream flags
// ---------------------------------------------------------------------------
module bits_packet_sequencer #(
  parameter int SUM_W = 16
) (
  input  logic             clk,
  input  logic             resetB,
  input  logic             start,
  input  logic             stream_end,
  input  logic [79:0]      win_bits,
  input  logic [6:0]       win_count,
  output logic             consume,
  output logic [6:0]       consume_n,
  output logic             lit_enable,
  output logic [79:0]      lit_bits,
  input  logic [15:0]      lit_valid_nibbles,
  input  logic [63:0]      lit_number,
  output logic             pkt_valid,
  output logic [2:0]       pkt_version,
  output logic [2:0]       pkt_type,
  output logic             literal_valid,
  output logic [63:0]      literal_value,
  output logic             op_valid,
  output logic             op_len_type,
  output logic [14:0]      op_len,
  output logic [SUM_W-1:0] version_sum,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE, HDR, LIT, LIT_WAIT, OP, DONE, ERR
  } seqState_t;

  seqState_t state;

  function automatic logic [4:0] popCount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0000, v[i]};
    return c;
  endfunction

  // Literal geometry: n nibbles occupy 5n window bits. number_top packs the
  // nibbles from bit 63 down, so the value is right-justified by 4*(16-n).
  logic [4:0] nibCnt;
  logic [6:0] litLen;
  logic [6:0] litShift;
  logic [6:0] opNeed;

  assign nibCnt   = popCount16(lit_valid_nibbles);
  assign litLen   = {nibCnt, 2'b00} + {2'b00, nibCnt};
  assign litShift = {5'd16 - nibCnt, 2'b00};
  // Length-type bit picks a 15-bit bit length or an 11-bit packet count.
  assign opNeed   = win_bits[79] ? 7'd12 : 7'd16;

  assign lit_bits = win_bits;
  assign busy     = (state != IDLE) && (state != DONE) && (state != ERR);

  always_ff @(posedge clk) begin
    if (!resetB) begin
      state         <= IDLE;
      consume       <= 1'b0;
      consume_n     <= '0;
      lit_enable    <= 1'b0;
      pkt_valid     <= 1'b0;
      pkt_version   <= '0;
      pkt_type      <= '0;
      literal_valid <= 1'b0;
      literal_value <= '0;
      op_valid      <= 1'b0;
      op_len_type   <= 1'b0;
      op_len        <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      consume       <= 1'b0;
      lit_enable    <= 1'b0;
      pkt_valid     <= 1'b0;
      literal_valid <= 1'b0;
      op_valid      <= 1'b0;

      // The shifter updates the window on the edge that samples consume,
      // so every window-reading state idles while consume is high.
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state <= HDR;
            done  <= 1'b0;
            error <= 1'b0;
          end
        end

        HDR: begin
          if (!consume) begin
            if (stream_end && (win_count < 7'd11)) begin
              // Fewer bits than the smallest packet: trailing padding.
              state <= DONE;
              done  <= 1'b1;
            end else if (win_count >= 7'd6) begin
              pkt_version <= win_bits[79:77];
              pkt_type    <= win_bits[76:74];
              pkt_valid   <= 1'b1;
              consume     <= 1'b1;
              consume_n   <= 7'd6;
              state       <= (win_bits[76:74] == 3'd4) ? LIT : OP;
            end
          end
        end

        LIT: begin
          // Either the window is full or it already holds every remaining
          // bit, so number_top sees the whole literal.
          if (!consume && ((win_count == 7'd80) || stream_end)) begin
            lit_enable <= 1'b1;
            state      <= LIT_WAIT;
          end
        end

        LIT_WAIT: begin
          // number_top registers on the lit_enable cycle; its result is
          // usable once lit_enable has dropped.
          if (!lit_enable) begin
            if ((nibCnt == 5'd16) && win_bits[4]) begin
              // 16th group still continues: literal wider than 64 bits.
              state <= ERR;
              error <= 1'b1;
            end else if (litLen > win_count) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              literal_value <= lit_number >> litShift;
              literal_valid <= 1'b1;
              consume       <= 1'b1;
              consume_n     <= litLen;
              state         <= HDR;
            end
          end
        end

        OP: begin
          if (!consume) begin
            if (win_count >= opNeed) begin
              op_len_type <= win_bits[79];
              op_len      <= win_bits[79] ? {4'b0000, win_bits[78:68]}
                                          : win_bits[78:64];
              op_valid    <= 1'b1;
              consume     <= 1'b1;
              consume_n   <= opNeed;
              state       <= HDR;
            end else if (stream_end) begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef BITS_VERSION_SUM_EN
  // Accumulates from the registered header pulse, so the sum trails
  // pkt_valid by one cycle. Cleared on every accepted start.
  logic [SUM_W-1:0] sumAcc;

  always_ff @(posedge clk) begin
    if (!resetB)             sumAcc <= '0;
    else if (start && !busy) sumAcc <= '0;
    else if (pkt_valid)      sumAcc <= sumAcc + SUM_W'(pkt_version);
  end

  assign version_sum = sumAcc;
`else
  assign version_sum = '0;
`endif

endmodule

// File: tb/tb_bits_packet_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bits_packet_sequencer
//
// Directed bench for bits_packet_sequencer. A small shifter model serves the
// bit window from a left-justified stream buffer. A number_top model decodes
// literal groups one cycle after lit_enable. Negedge recorders log every
// consume, header, literal and operator pulse into queues, and the main
// sequence compares those logs against hand-decoded packet contents.
// ---------------------------------------------------------------------------
module tb_bits_packet_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetB;
  logic        start;
  logic        stream_end;
  logic [79:0] win_bits;
  logic [6:0]  win_count;
  logic        consume;
  logic [6:0]  consume_n;
  logic        lit_enable;
  logic [79:0] lit_bits;
  logic [15:0] lit_valid_nibbles;
  logic [63:0] lit_number;
  logic        pkt_valid;
  logic [2:0]  pkt_version;
  logic [2:0]  pkt_type;
  logic        literal_valid;
  logic [63:0] literal_value;
  logic        op_valid;
  logic        op_len_type;
  logic [14:0] op_len;
  logic [15:0] version_sum;
  logic        busy;
  logic        done;
  logic        error;

  bits_packet_sequencer #(.SUM_W(16)) dut (
    .clk(clk), .resetB(resetB), .start(start), .stream_end(stream_end),
    .win_bits(win_bits), .win_count(win_count),
    .consume(consume), .consume_n(consume_n),
    .lit_enable(lit_enable), .lit_bits(lit_bits),
    .lit_valid_nibbles(lit_valid_nibbles), .lit_number(lit_number),
    .pkt_valid(pkt_valid), .pkt_version(pkt_version), .pkt_type(pkt_type),
    .literal_valid(literal_valid), .literal_value(literal_value),
    .op_valid(op_valid), .op_len_type(op_len_type), .op_len(op_len),
    .version_sum(version_sum), .busy(busy), .done(done), .error(error)
  );

  // ---- shifter model ------------------------------------------------------
  logic [511:0] sbuf = '0;
  int           sLen = 0;
  int           ptr = 0;
  logic [511:0] shBuf;
  int           remBits;

  always @(posedge clk) begin
    if (start)        ptr <= 0;
    else if (consume) ptr <= ptr + int'(consume_n);
  end

  assign shBuf      = sbuf << ptr;
  assign remBits    = sLen - ptr;
  assign win_bits   = shBuf[511:432];
  assign win_count  = (remBits > 80) ? 7'd80 : ((remBits < 0) ? 7'd0 : 7'(remBits));
  assign stream_end = (remBits <= 80);

  // ---- number_top model ---------------------------------------------------
  function automatic logic [79:0] numberTop(input logic [79:0] b);
    logic [63:0] num;
    logic [15:0] vn;
    logic        go;
    num = '0;
    vn  = '0;
    go  = 1'b1;
    for (int g = 0; g < 16; g++) begin
      if (go) begin
        vn[g]             = 1'b1;
        num[63-4*g -: 4]  = b[78-5*g -: 4];
        go                = b[79-5*g];
      end
    end
    return {vn, num};
  endfunction

  always @(posedge clk) begin
    if (lit_enable) {lit_valid_nibbles, lit_number} <= numberTop(lit_bits);
  end

  // ---- pulse recorders ----------------------------------------------------
  int          consQ[$];
  logic [5:0]  pktQ[$];
  logic [63:0] litQ[$];
  logic [15:0] opQ[$];
  int          multiHot = 0;

  always @(negedge clk) begin
    if (consume)       consQ.push_back(int'(consume_n));
    if (pkt_valid)     pktQ.push_back({pkt_version, pkt_type});
    if (literal_valid) litQ.push_back(literal_value);
    if (op_valid)      opQ.push_back({op_len_type, op_len});
    if (int'(pkt_valid) + int'(literal_valid) + int'(op_valid) > 1) multiHot <= multiHot + 1;
  end

  // ---- checking helpers ---------------------------------------------------
  int checks = 0;
  int errors = 0;
  int cb, pb, lb, ob;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] expSum(input int s);
`ifdef BITS_VERSION_SUM_EN
    return 64'(s);
`else
    return 64'(s - s);
`endif
  endfunction

  task automatic loadStream(input logic [255:0] v, input int nbits);
    sbuf          = '0;
    sbuf[511:256] = v << (256 - nbits);
    sLen          = nbits;
    cb = consQ.size();
    pb = pktQ.size();
    lb = litQ.size();
    ob = opQ.size();
  endtask

  task automatic pulseStart();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic waitEnd(input string tag);
    int n = 0;
    while (!(done || error) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 500), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  logic [255:0] errV;

  initial begin
    resetB = 1'b0;
    start  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_consume", consume, 0);
    chk("rst_consume_n", consume_n, 0);
    chk("rst_pulses", {lit_enable, pkt_valid, literal_valid, op_valid}, 0);
    chk("rst_pkt", {pkt_version, pkt_type}, 0);
    chk("rst_literal_value", literal_value, 0);
    chk("rst_op", {op_len_type, op_len}, 0);
    chk("rst_version_sum", version_sum, 0);
    chk("rst_flags", {busy, done, error}, 0);
    resetB = 1'b1;
    @(negedge clk);

    // D2FE28: single literal 0x7E5
    loadStream(256'hD2FE28, 24);
    pulseStart();
    waitEnd("d2_end");
    chk("d2_flags", {done, error}, 2'b10);
    chk("d2_ncons", consQ.size() - cb, 2);
    chk("d2_cons0", consQ[cb], 6);
    chk("d2_cons1", consQ[cb+1], 15);
    chk("d2_pkt", pktQ[pb], {3'd6, 3'd4});
    chk("d2_lit", litQ[lb], 64'h7E5);
    chk("d2_sum", version_sum, expSum(6));

    // 38006F45291200: operator, bit-length 27, literals 10 and 20
    loadStream(256'h38006F45291200, 56);
    pulseStart();
    waitEnd("op0_end");
    chk("op0_flags", {done, error}, 2'b10);
    chk("op0_ncons", consQ.size() - cb, 6);
    chk("op0_cons1", consQ[cb+1], 16);
    chk("op0_cons3", consQ[cb+3], 5);
    chk("op0_cons5", consQ[cb+5], 10);
    chk("op0_pkt0", pktQ[pb], {3'd1, 3'd6});
    chk("op0_pkt2", pktQ[pb+2], {3'd2, 3'd4});
    chk("op0_op", opQ[ob], {1'b0, 15'd27});
    chk("op0_lit0", litQ[lb], 64'd10);
    chk("op0_lit1", litQ[lb+1], 64'd20);
    chk("op0_sum", version_sum, expSum(9));

    // EE00D40C823060: operator, packet count 3, literals 1 2 3
    loadStream(256'hEE00D40C823060, 56);
    pulseStart();
    waitEnd("op1_end");
    chk("op1_flags", {done, error}, 2'b10);
    chk("op1_ncons", consQ.size() - cb, 8);
    chk("op1_cons1", consQ[cb+1], 12);
    chk("op1_pkt0", pktQ[pb], {3'd7, 3'd3});
    chk("op1_op", opQ[ob], {1'b1, 15'd3});
    chk("op1_nlit", litQ.size() - lb, 3);
    chk("op1_lit0", litQ[lb], 64'd1);
    chk("op1_lit1", litQ[lb+1], 64'd2);
    chk("op1_lit2", litQ[lb+2], 64'd3);
    chk("op1_sum", version_sum, expSum(14));

    // 8A004A801A8002F478: nested operators, version sum 16
    loadStream(256'h8A004A801A8002F478, 72);
    pulseStart();
    waitEnd("vs_end");
    chk("vs_flags", {done, error}, 2'b10);
    chk("vs_sum", version_sum, expSum(16));
    chk("vs_lit", litQ[litQ.size()-1], 64'd15);
    chk("vs_nop", opQ.size() - ob, 3);

    // Header 110100 followed by 16 continuing groups: literal overflow
    errV        = '0;
    errV[85:0]  = {6'b110100, {80{1'b1}}};
    loadStream(errV, 86);
    pulseStart();
    waitEnd("ovf_end");
    repeat (5) @(negedge clk);
    chk("ovf_flags", {busy, done, error}, 3'b001);
    chk("ovf_ncons", consQ.size() - cb, 1);
    chk("ovf_cons0", consQ[cb], 6);
    chk("ovf_nlit", litQ.size() - lb, 0);

    // Reset while in LIT_WAIT, then re-parse D2FE28
    loadStream(256'hD2FE28, 24);
    pulseStart();
    begin
      int n = 0;
      while (!lit_enable && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rlw_saw_enable", lit_enable, 1);
    resetB = 1'b0;
    @(negedge clk);
    chk("rlw_consume", consume, 0);
    chk("rlw_ncons", consQ.size() - cb, 1);
    chk("rlw_pulses", {lit_enable, pkt_valid, literal_valid, op_valid}, 0);
    chk("rlw_regs", {consume_n, pkt_version, pkt_type, op_len_type, op_len}, 0);
    chk("rlw_sum", version_sum, 0);
    chk("rlw_flags", {busy, done, error}, 0);
    @(negedge clk);
    resetB = 1'b1;
    loadStream(256'hD2FE28, 24);
    pulseStart();
    waitEnd("rlw_end");
    chk("rlw_done", {done, error}, 2'b10);
    chk("rlw_lit", litQ[lb], 64'h7E5);
    chk("rlw_cons1", consQ[cb+1], 15);
    chk("rlw_sum2", version_sum, expSum(6));

    chk("one_hot_pulses", 64'(multiHot), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
